im_loader_arb: RTL



---
 rtl/im_loader_arb_if.sv | 48 ++++
 rtl/im_loader_arb.sv | 125 ++++++++++++
 2 files changed

// File: rtl/im_loader_arb_if.sv
// im_loader_arb_if: loader, fetch and instruction-memory pins of the IM controller.
// Revision: 1.0
`default_nettype none

interface im_loader_arb_if #(
  parameter int LEN_W = 17
);
  logic             load_start;
  logic [15:0]      load_base;
  logic [LEN_W-1:0] load_len;
  logic             load_abort;
  logic             load_valid;
  logic [31:0]      load_data;
  logic             load_ready;
  logic             load_done;
  logic             load_aborted;
  logic             busy;
  logic             fetch_req;
  logic [15:0]      fetch_addr;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [31:0]      fetch_data;
  logic             IM_enable;
  logic             IM_write;
  logic [15:0]      IM_address;
  logic [31:0]      IM_in;
  logic [31:0]      IM_out;

  // Controller side.
  modport slave (
    input  load_start, load_base, load_len, load_abort, load_valid, load_data,
    input  fetch_req, fetch_addr, IM_out,
    output load_ready, load_done, load_aborted, busy,
    output fetch_ready, fetch_valid, fetch_data,
    output IM_enable, IM_write, IM_address, IM_in
  );

  // Requester / memory side.
  modport master (
    output load_start, load_base, load_len, load_abort, load_valid, load_data,
    output fetch_req, fetch_addr, IM_out,
    input  load_ready, load_done, load_aborted, busy,
    input  fetch_ready, fetch_valid, fetch_data,
    input  IM_enable, IM_write, IM_address, IM_in
  );
endinterface

`default_nettype wire

// File: rtl/im_loader_arb.sv
// im_loader_arb: single-port instruction-memory owner; loader writes take priority over fetch reads.
// Revision: 1.0
`default_nettype none

module im_loader_arb #(
  parameter int LEN_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  im_loader_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             aborted_q, aborted_d;
  logic             fetch_valid_q;
  logic [31:0]      fetch_data_q;

  logic             fetch_fire;
  logic             im_enable_n;
  logic             im_write_n;
  logic [15:0]      im_address;
  logic [31:0]      im_in;

  assign fetch_fire = bus.fetch_req && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      aborted_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      aborted_q     <= aborted_d;
      fetch_valid_q <= fetch_fire;
      if (fetch_fire) begin
        fetch_data_q <= bus.IM_out;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    aborted_d   = aborted_q;
    im_enable_n = 1'b1;
    im_write_n  = 1'b1;
    im_address  = '0;
    im_in       = '0;

    case (state_q)
      S_IDLE: begin
        // Keep the memory pins quiet while reset is held, even if a fetch is requested.
        if (bus.fetch_req && rst_n) begin
          im_enable_n = 1'b0;
          im_address  = bus.fetch_addr;
        end
        if (bus.load_start) begin
          aborted_d = 1'b0;
          if (bus.load_len != '0) begin
            addr_d      = bus.load_base;
            remaining_d = bus.load_len;
            state_d     = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        // Abort outranks a word presented in the same cycle: that word is dropped.
        if (bus.load_abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (bus.load_valid) begin
          im_enable_n = 1'b0;
          im_write_n  = 1'b0;
          im_address  = addr_q;
          im_in       = bus.load_data;
          addr_d      = addr_q + 16'd1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.load_ready   = (state_q == S_LOAD);
  assign bus.fetch_ready  = (state_q == S_IDLE);
  assign bus.load_done    = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.load_aborted = aborted_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.fetch_data   = fetch_data_q;
  assign bus.IM_enable    = im_enable_n;
  assign bus.IM_write     = im_write_n;
  assign bus.IM_address   = im_address;
  assign bus.IM_in        = im_in;

endmodule

`default_nettype wire
